// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the EX-stage sequential multiplier:
//   - state_t : FSM encoding of mul_seq_unit (IDLE=0, RUN=1, FIX=2,
//               ACC_LO=3, ACC_HI=4; the ACC states are only reached when
//               MUL_SEQ_MADD_EN is defined)
//   - W_DEF   : default datapath width shared with the rest of the core
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int W_DEF = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_FIX    = 3'd2,
        S_ACC_LO = 3'd3,
        S_ACC_HI = 3'd4
    } state_t;

endpackage

// File: rtl/mul_seq_unit_adder.sv
// ---------------------------------------------------------------------------
// adder
// Plain n-bit ripple-carry adder, shared by the multiplier for both the
// partial-product iterations and the MADD accumulate steps.
// Ports:
//   i_a, i_b : n-bit addends
//   i_ci     : carry in
//   o_s      : n-bit sum
//   o_co     : carry out of the top bit
// ---------------------------------------------------------------------------
module adder #(
    parameter int n = 32
) (
    input  logic [n-1:0] i_a,
    input  logic [n-1:0] i_b,
    input  logic         i_ci,
    output logic [n-1:0] o_s,
    output logic         o_co
);

    logic [n:0] w_c;

    assign w_c[0] = i_ci;

    for (genvar g = 0; g < n; g++) begin : g_fa
        assign o_s[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_co = w_c[n];

endmodule

// File: rtl/mul_seq_unit.sv
// ---------------------------------------------------------------------------
// mul_seq_unit
// Sequential W x W -> 2W shift-and-add multiplier holding the HI/LO pair
// (MULT/MULTU, MTHI/MTLO). One partial-product addition per cycle through
// the shared ripple-carry adder; signed operands are multiplied as
// magnitudes and the product is negated in FIX.
//
// Optional feature, macro MUL_SEQ_MADD_EN: when defined, accumulate latched
// at start adds the product into {hi,lo} through two extra adder passes
// (ACC_LO, ACC_HI), giving 35-cycle latency instead of 33. When undefined,
// accumulate is ignored.
//
// Handshake: start is sampled only while busy=0; the result is in hi/lo
// in the cycle done=1, and a new start is accepted in that same cycle.
// hi_we/lo_we are honoured only while busy=0.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start          : begin a multiply (IDLE only)
//   is_signed      : 1 = MULT, 0 = MULTU
//   accumulate     : MADD/MADDU request (used only with MUL_SEQ_MADD_EN)
//   a, b           : multiplicand / multiplier
//   hi_we, lo_we   : MTHI / MTLO write enables, data on wdata
//   busy           : high while not IDLE (combinational)
//   done           : registered one-cycle result pulse
//   hi, lo         : HI / LO registers
//   o_dbg_state    : current FSM state (debug observation)
// ---------------------------------------------------------------------------
module mul_seq_unit
    import mips_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         is_signed,
    input  logic         accumulate,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [W-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic [2:0]   o_dbg_state
);

    state_t             r_state;
    logic [W-1:0]       r_hi;
    logic [W-1:0]       r_lo;
    logic [W-1:0]       r_mcand;
    logic [W-1:0]       r_p;
    logic [W-1:0]       r_m;
    logic               r_neg;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;

`ifdef MUL_SEQ_MADD_EN
    logic               r_acc;
    logic [2*W-1:0]     r_prod;
    logic [W-1:0]       r_sum_lo;
`else
    logic               w_unused_acc;
    assign w_unused_acc = accumulate;
`endif

    logic [W-1:0]       w_mag_a;
    logic [W-1:0]       w_mag_b;
    logic [2*W-1:0]     w_prod;
    logic [2*W-1:0]     w_prod_fix;
    logic [W-1:0]       w_add_a;
    logic [W-1:0]       w_add_b;
    logic               w_add_ci;
    logic [W-1:0]       w_add_s;
    logic               w_add_co;

    // Magnitudes; -(0x80..0) wraps to 0x80..0, which is the right unsigned
    // magnitude, so no special case is needed.
    assign w_mag_a = (is_signed && a[W-1]) ? (~a + 1'b1) : a;
    assign w_mag_b = (is_signed && b[W-1]) ? (~b + 1'b1) : b;

    assign w_prod     = {r_p, r_m};
    assign w_prod_fix = r_neg ? (~w_prod + 1'b1) : w_prod;

    // Adder input mux: partial-product step by default, HI/LO accumulate
    // in the ACC states.
    always_comb begin
        w_add_a  = r_p;
        w_add_b  = r_m[0] ? r_mcand : '0;
        w_add_ci = 1'b0;
`ifdef MUL_SEQ_MADD_EN
        if (r_state == S_ACC_LO) begin
            w_add_a = r_lo;
            w_add_b = r_prod[W-1:0];
        end else if (r_state == S_ACC_HI) begin
            w_add_a  = r_hi;
            w_add_b  = r_prod[2*W-1:W];
            w_add_ci = r_carry;
        end
`endif
    end

    adder #(.n(W)) u_adder (
        .i_a  (w_add_a),
        .i_b  (w_add_b),
        .i_ci (w_add_ci),
        .o_s  (w_add_s),
        .o_co (w_add_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_mcand <= '0;
            r_p     <= '0;
            r_m     <= '0;
            r_neg   <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
`ifdef MUL_SEQ_MADD_EN
            r_acc    <= 1'b0;
            r_prod   <= '0;
            r_sum_lo <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start) begin
                        r_mcand <= w_mag_a;
                        r_m     <= w_mag_b;
                        r_neg   <= is_signed & (a[W-1] ^ b[W-1]);
                        r_p     <= '0;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
`ifdef MUL_SEQ_MADD_EN
                        r_acc   <= accumulate;
`endif
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // {P,M} <= {co,s,M} >> 1 : the sum's LSB is a finished
                    // product bit and shifts into the top of M.
                    r_p <= {w_add_co, w_add_s[W-1:1]};
                    r_m <= {w_add_s[0], r_m[W-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(W - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
`ifdef MUL_SEQ_MADD_EN
                    if (r_acc) begin
                        r_prod  <= w_prod_fix;
                        r_state <= S_ACC_LO;
                    end else begin
                        r_hi    <= w_prod_fix[2*W-1:W];
                        r_lo    <= w_prod_fix[W-1:0];
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
`else
                    r_hi    <= w_prod_fix[2*W-1:W];
                    r_lo    <= w_prod_fix[W-1:0];
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
`endif
                end
`ifdef MUL_SEQ_MADD_EN
                S_ACC_LO: begin
                    // Hold the low sum until ACC_HI so hi/lo change together.
                    r_sum_lo <= w_add_s;
                    r_carry  <= w_add_co;
                    r_state  <= S_ACC_HI;
                end
                S_ACC_HI: begin
                    r_hi    <= w_add_s;
                    r_lo    <= r_sum_lo;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mul_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_seq_unit
// Directed bench for mul_seq_unit with hand-computed products. Inputs are
// driven and outputs sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_mul_seq_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic         accumulate;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [2:0]   o_dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_seq_unit #(.W(W), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .accumulate  (accumulate),
        .a           (a),
        .b           (b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .o_dbg_state (o_dbg_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one multiply and wait (bounded) for done. With interfere=1 a
    // second start (a=b=1) arrives at cycle 10 and an MTHI of 0xDEAD at
    // cycle 12; both must be ignored.
    task automatic run_mul(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic sgn, input logic acc, input bit interfere,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                           input int exp_lat);
        int n;
        int busy_cnt;
        a = va; b = vb; is_signed = sgn; accumulate = acc; start = 1'b1;
        step();
        start = 1'b0;
        // Operands scrambled after the start edge must have no effect.
        a = 32'h5A5A_5A5A; b = 32'hA5A5_A5A5; is_signed = ~sgn;
        chk({tag, "_state_run"}, 64'(o_dbg_state), 64'd1);
        n = 0;
        busy_cnt = 0;
        while (!done && n < 100) begin
            if (busy) busy_cnt++;
            if (interfere) begin
                if (n == 10) begin start = 1'b1; a = 1; b = 1; end
                if (n == 11) start = 1'b0;
                if (n == 12) begin hi_we = 1'b1; wdata = 32'h0000_DEAD; end
                if (n == 13) hi_we = 1'b0;
            end
            step();
            n++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        step();
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int dcnt;
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; accumulate = 1'b0;
        a = '0; b = '0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_hi",    64'(hi),   64'd0);
        chk("rst_lo",    64'(lo),   64'd0);
        chk("rst_state", 64'(o_dbg_state), 64'd0);

        run_mul("u7x6", 32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_002A, 33);
        run_mul("s_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, 1'b0,
                32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
        run_mul("u_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0,
                32'hFFFF_FFFE, 32'h0000_0001, 33);
        run_mul("s_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0,
                32'h4000_0000, 32'h0, 33);
        run_mul("zero", 32'h0, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 33);
        run_mul("busy_rules", 32'd7, 32'd6, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_002A, 33);

        // MTHI/MTLO in IDLE, and an MTLO in the same cycle as start.
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1357_9BDF;
        step();
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthi", 64'(hi), 64'h1357_9BDF);
        chk("mtlo", 64'(lo), 64'h1357_9BDF);
        lo_we = 1'b1; wdata = 32'h0000_BEEF; a = 32'd3; b = 32'd3; start = 1'b1;
        step();
        lo_we = 1'b0; start = 1'b0;
        chk("mtlo_with_start_lo", 64'(lo), 64'h0000_BEEF);
        chk("mtlo_with_start_busy", 64'(busy), 64'd1);

        // Abandon that multiply with a reset in the middle of RUN.
        for (int i = 0; i < 14; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hi",   64'(hi),   64'd0);
        chk("midrst_lo",   64'(lo),   64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dcnt++;
            step();
        end
        chk("midrst_no_done", 64'(dcnt), 64'd0);
        chk("midrst_lo_hold", 64'(lo), 64'd0);
        run_mul("after_rst", 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h6, 33);

        // MADDU 1*1 onto {0, 0xFFFFFFFF}.
        hi_we = 1'b1; wdata = 32'h0;
        step();
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hFFFF_FFFF;
        step();
        lo_we = 1'b0;
        chk("pre_hi", 64'(hi), 64'h0);
        chk("pre_lo", 64'(lo), 64'hFFFF_FFFF);
`ifdef MUL_SEQ_MADD_EN
        run_mul("maddu", 32'd1, 32'd1, 1'b0, 1'b1, 1'b0, 32'h1, 32'h0, 35);
`else
        run_mul("maddu", 32'd1, 32'd1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1, 33);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
